// File: rtl/ed_fout_packetizer_pkg.sv
// Shared definitions for the energy-detection fout packetizer: header tag,
// window index width and FSM state encoding.
package ed_fout_packetizer_pkg;

  localparam logic [15:0] HDR_TAG_DEF = 16'hED01;
  localparam int          WIN_IDX_W   = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR0,
    S_HDR1,
    S_STREAM,
    S_DISCARD
  } state_t;

endpackage

// File: rtl/ed_fout_packetizer_event_slot.sv
// One-deep pending-event register. Holds a window-end event that arrives while
// the packetizer is busy; flags a drop when a new event finds the slot occupied.
module ed_event_slot #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_data,
  output logic         o_full,
  output logic [W-1:0] o_data,
  output logic         o_drop
);

  logic         r_full;
  logic [W-1:0] r_data;

  // A push in the same cycle as the unload refills the slot instead of dropping.
  assign o_drop = i_push & r_full & ~i_pop;
  assign o_full = r_full;
  assign o_data = r_data;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else if (i_push & ~o_drop) begin
      r_full <= 1'b1;
      r_data <= i_data;
    end else if (i_pop) begin
      r_full <= 1'b0;
    end
  end

endmodule

// File: rtl/ed_fout_packetizer.sv
// Drains one detection window from fout per end_sig: detected windows go out as an
// AXI-Stream packet (two header words + samples), others are popped and discarded.
module ed_fout_packetizer
  import ed_fout_packetizer_pkg::*;
#(
  parameter int          DATA_W   = 32,
  parameter int          ENERGY_W = 48,
  parameter int          WIN_LEN  = 1024,
  parameter int          CNT_W    = 11,
  parameter logic [15:0] HDR_TAG  = HDR_TAG_DEF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                end_sig,
  input  logic                det_result,
  input  logic [ENERGY_W-1:0] energy_in,
  input  logic [DATA_W-1:0]   fout_dout,
  input  logic                fout_empty,
  output logic                fout_pop,
  output logic [DATA_W-1:0]   m_tdata,
  output logic                m_tvalid,
  input  logic                m_tready,
  output logic                m_tlast,
  output logic                busy,
  output logic [7:0]          overrun_cnt
);

  localparam int              JOB_W    = 1 + ENERGY_W + WIN_IDX_W;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIN_LEN - 1);

  state_t                       r_state, w_next;
  logic [WIN_IDX_W-1:0]         r_win_idx, r_job_idx;
  logic                         r_det;
  logic [ENERGY_W-1:0]          r_energy;
  logic [CNT_W-1:0]             r_cnt;
  logic [7:0]                   r_overrun;

  logic                         w_idle, w_direct, w_slot_push, w_slot_pop;
  logic                         w_slot_full, w_drop, w_job_load, w_last, w_ovf;
  logic [JOB_W-1:0]             w_event, w_slot_data, w_job;
  logic [ENERGY_W+DATA_W-1:0]   w_energy_ext;
  logic [DATA_W-1:0]            w_hdr0, w_hdr1;

  assign w_idle      = (r_state == S_IDLE);
  assign w_direct    = end_sig & w_idle & ~w_slot_full;
  assign w_slot_push = end_sig & ~w_direct;
  // A waiting event always wins the IDLE slot over a fresh end_sig.
  assign w_slot_pop  = w_idle & w_slot_full;
  assign w_job_load  = w_direct | w_slot_pop;
  assign w_event     = {det_result, energy_in, r_win_idx};
  assign w_job       = w_slot_pop ? w_slot_data : w_event;

  ed_event_slot #(.W(JOB_W)) u_slot (
    .clock  (clock),
    .reset  (reset),
    .i_push (w_slot_push),
    .i_pop  (w_slot_pop),
    .i_data (w_event),
    .o_full (w_slot_full),
    .o_data (w_slot_data),
    .o_drop (w_drop)
  );

  // Energy wider than the stream word saturates rather than wrapping.
  assign w_energy_ext = {{DATA_W{1'b0}}, r_energy};
  assign w_ovf        = |(w_energy_ext >> DATA_W);
  assign w_hdr1       = w_ovf ? '1 : w_energy_ext[DATA_W-1:0];
  assign w_hdr0       = DATA_W'({HDR_TAG, r_job_idx});
  assign w_last       = (r_cnt == LAST_CNT);

  assign busy        = ~w_idle | w_slot_full;
  assign overrun_cnt = r_overrun;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    fout_pop = 1'b0;
    m_tvalid = 1'b0;
    m_tdata  = '0;
    m_tlast  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_job_load) w_next = w_job[JOB_W-1] ? S_HDR0 : S_DISCARD;
      end
      S_HDR0: begin
        m_tvalid = 1'b1;
        m_tdata  = w_hdr0;
        if (m_tready) w_next = S_HDR1;
      end
      S_HDR1: begin
        m_tvalid = 1'b1;
        m_tdata  = w_hdr1;
        if (m_tready) w_next = S_STREAM;
      end
      S_STREAM: begin
        m_tvalid = ~fout_empty;
        m_tdata  = fout_dout;
        m_tlast  = w_last;
        fout_pop = m_tvalid & m_tready;
        if (fout_pop && w_last) w_next = S_IDLE;
      end
      S_DISCARD: begin
        fout_pop = ~fout_empty;
        if (fout_pop && w_last) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_win_idx <= '0;
      r_job_idx <= '0;
      r_det     <= 1'b0;
      r_energy  <= '0;
      r_cnt     <= '0;
      r_overrun <= '0;
    end else begin
      if (end_sig)    r_win_idx <= r_win_idx + 1'b1;
      if (w_job_load) {r_det, r_energy, r_job_idx} <= w_job;
      if (w_idle)        r_cnt <= '0;
      else if (fout_pop) r_cnt <= r_cnt + 1'b1;
      if (w_drop && r_overrun != 8'hFF) r_overrun <= r_overrun + 1'b1;
    end
  end

endmodule

// File: tb/tb_ed_fout_packetizer.sv
// Self-checking bench for ed_fout_packetizer: queue-based fout model and an
// expected-beat scoreboard built from window events.
module tb_ed_fout_packetizer;
  localparam int DATA_W   = 32;
  localparam int ENERGY_W = 48;
  localparam int WIN_LEN  = 4;
  localparam int CNT_W    = 3;
  typedef logic [DATA_W:0] beat_t;   // {tlast, tdata}

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic                end_sig = 1'b0, det_result = 1'b0;
  logic [ENERGY_W-1:0] energy_in = '0;
  logic [DATA_W-1:0]   fout_dout, m_tdata;
  logic                fout_empty, fout_pop, m_tvalid, m_tlast, busy;
  logic                m_tready = 1'b1;
  logic [7:0]          overrun_cnt;

  always #5 clock = ~clock;

  ed_fout_packetizer #(.DATA_W(DATA_W), .ENERGY_W(ENERGY_W), .WIN_LEN(WIN_LEN),
                       .CNT_W(CNT_W), .HDR_TAG(16'hED01)) dut (
    .clock(clock), .reset(reset), .end_sig(end_sig), .det_result(det_result),
    .energy_in(energy_in), .fout_dout(fout_dout), .fout_empty(fout_empty),
    .fout_pop(fout_pop), .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tlast(m_tlast), .busy(busy), .overrun_cnt(overrun_cnt));

  int errors = 0, checks = 0;
  beat_t got[$], exp[$];
  logic [DATA_W-1:0] fq[$];
  logic gate = 1'b0;
  int gate_hold = 0, gate_pct = 0, rdy_mode = 0;
  int pops = 0, vld_cycles = 0;
  logic p_vld = 1'b0, p_rdy = 1'b0, p_last = 1'b0;
  logic [DATA_W-1:0] p_data = '0;
  logic [15:0] tb_idx = '0;

  function automatic logic [DATA_W-1:0] sat_energy(input logic [ENERGY_W-1:0] e);
    logic [ENERGY_W-1:0] lim;
    lim = ENERGY_W'(1) << DATA_W;
    if (e >= lim) return '1;
    return e[DATA_W-1:0];
  endfunction

  function automatic void drive_fout();
    fout_empty = gate || (fq.size() == 0);
    fout_dout  = (fq.size() != 0) ? fq[0] : '0;
  endfunction

  // Models one window event: its samples enter fout (unless dropped) and, when
  // detected, the expected packet is appended to the scoreboard.
  task automatic add_window(input logic det, input logic [ENERGY_W-1:0] e, input bit keep, input int base);
    logic [DATA_W-1:0] s;
    if (keep) begin
      if (det) begin
        exp.push_back({1'b0, 16'hED01, tb_idx});
        exp.push_back({1'b0, sat_energy(e)});
      end
      for (int i = 0; i < WIN_LEN; i++) begin
        s = (base != 0) ? DATA_W'(base + i) : DATA_W'($urandom);
        fq.push_back(s);
        if (det) exp.push_back({i == WIN_LEN - 1, s});
      end
    end
    tb_idx++;
  endtask

  task automatic fire(input logic det, input logic [ENERGY_W-1:0] e, input bit keep, input int base);
    end_sig = 1'b1; det_result = det; energy_in = e;
    add_window(det, e, keep, base);
    drive_fout();
  endtask

  function automatic logic [ENERGY_W-1:0] rand_energy();
    logic [ENERGY_W-1:0] e;
    e[31:0]  = $urandom;
    e[47:32] = $urandom_range(0, 1) ? 16'($urandom) : 16'h0;
    return e;
  endfunction

  task automatic clear_model();
    fq.delete(); got.delete(); exp.delete();
    tb_idx = '0; gate = 1'b0; gate_hold = 0; gate_pct = 0; rdy_mode = 0;
    p_vld = 1'b0; p_rdy = 1'b0; end_sig = 1'b0; m_tready = 1'b1;
    drive_fout();
  endtask

  // One clock: sample at negedge (what the DUT sees at the edge), advance fout after it.
  task automatic tick();
    logic s_pop, s_vld, s_rdy, s_last, s_empty, allow;
    logic [DATA_W-1:0] s_data;
    @(negedge clock);
    s_pop = fout_pop; s_vld = m_tvalid; s_rdy = m_tready; s_last = m_tlast;
    s_data = m_tdata; s_empty = fout_empty;
    if (s_pop) begin
      checks++;
      if (s_empty) begin errors++; $display("FAIL pop_when_empty pop=%b empty=%b", s_pop, s_empty); end
    end
    if (p_vld && !p_rdy) begin
      checks++;
      if (!(s_vld === 1'b1 && s_data === p_data && s_last === p_last)) begin
        errors++;
        $display("FAIL hold_stable vld=%b data=%h last=%b want vld=1 data=%h last=%b",
                 s_vld, s_data, s_last, p_data, p_last);
      end
    end
    if (s_vld && s_rdy) got.push_back({s_last, s_data});
    if (s_pop) pops++;
    if (s_vld) vld_cycles++;
    p_vld = s_vld; p_rdy = s_rdy; p_last = s_last; p_data = s_data;
    @(posedge clock); #1;
    end_sig = 1'b0;
    if (s_pop && fq.size() != 0) void'(fq.pop_front());
    if (rdy_mode == 1) m_tready = 1'($urandom_range(0, 1));
    else if (rdy_mode == 2) m_tready = ~m_tready;
    // fout may only look empty again once its visible head has been consumed
    allow = gate || s_empty || s_pop;
    if (allow && gate_hold > 0) begin gate = 1'b1; gate_hold--; end
    else if (allow && int'($urandom_range(0, 99)) < gate_pct) gate = 1'b1;
    else gate = 1'b0;
    drive_fout();
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    clear_model();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_model();
    fq.push_back(32'hDEAD_BEEF);
    drive_fout();
    repeat (2) @(posedge clock);
    #1;
    checks++; if (fout_pop !== 1'b0) begin errors++; $display("FAIL rst_pop got=%b want=0", fout_pop); end
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid got=%b want=0", m_tvalid); end
    checks++; if (m_tlast !== 1'b0) begin errors++; $display("FAIL rst_tlast got=%b want=0", m_tlast); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b want=0", busy); end
    checks++; if (m_tdata !== '0) begin errors++; $display("FAIL rst_tdata got=%h want=0", m_tdata); end
    checks++; if (overrun_cnt !== 8'd0) begin errors++; $display("FAIL rst_overrun got=%0d want=0", overrun_cnt); end
    reset = 1'b0;
    fq.delete();
    drive_fout();
  endtask

  task automatic test_packet();
    got.delete(); exp.delete(); pops = 0;
    m_tready = 1'b1;
    fire(1'b1, 48'h100, 1'b1, 32'hA0);
    repeat (7) tick();
    checks++;
    if (got.size() != 6) begin errors++; $display("FAIL pkt_len got=%0d want=6", got.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp[i]) begin errors++; $display("FAIL pkt_word[%0d] got=%h want=%h", i, got[i], exp[i]); end
    end
    checks++; if (pops != 4) begin errors++; $display("FAIL pkt_pops got=%0d want=4", pops); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL pkt_idle busy=%b want=0", busy); end
  endtask

  task automatic test_discard();
    pops = 0; vld_cycles = 0;
    fire(1'b0, 48'h7, 1'b1, 0);
    repeat (5) tick();
    checks++; if (pops != 4) begin errors++; $display("FAIL disc_pops got=%0d want=4", pops); end
    checks++; if (vld_cycles != 0) begin errors++; $display("FAIL disc_tvalid cycles=%0d want=0", vld_cycles); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL disc_idle busy=%b want=0", busy); end
    checks++; if (fq.size() != 0) begin errors++; $display("FAIL disc_left got=%0d want=0", fq.size()); end
  endtask

  task automatic test_stall();
    got.delete(); exp.delete(); pops = 0;
    rdy_mode = 2; m_tready = 1'b1;
    fire(1'b1, 48'h55, 1'b1, 0);
    tick();
    for (int i = 0; i < 100 && busy; i++) begin
      if (i == 3) gate_hold = 3;
      tick();
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_timeout busy=%b want=0", busy); end
    checks++;
    if (got.size() != exp.size()) begin errors++; $display("FAIL stall_len got=%0d want=%0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp[i]) begin errors++; $display("FAIL stall_word[%0d] got=%h want=%h", i, got[i], exp[i]); end
    end
    checks++; if (pops != WIN_LEN) begin errors++; $display("FAIL stall_pops got=%0d want=%0d", pops, WIN_LEN); end
    rdy_mode = 0; m_tready = 1'b1;
  endtask

  task automatic test_back_to_back();
    got.delete(); exp.delete();
    rdy_mode = 1; gate_pct = 25;
    for (int w = 0; w < 24; w++) begin
      fire(1'($urandom_range(0, 1)), rand_energy(), 1'b1, 0);
      tick();
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(0, 3)) tick();
        fire(1'($urandom_range(0, 1)), rand_energy(), 1'b1, 0);
        tick();
      end
      for (int i = 0; i < 400 && busy; i++) tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_timeout win=%0d busy=%b", w, busy); end
    end
    checks++;
    if (got.size() != exp.size()) begin errors++; $display("FAIL b2b_len got=%0d want=%0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp[i]) begin errors++; $display("FAIL b2b_word[%0d] got=%h want=%h", i, got[i], exp[i]); end
    end
    checks++; if (fq.size() != 0) begin errors++; $display("FAIL b2b_fout_left got=%0d want=0", fq.size()); end
    checks++; if (overrun_cnt !== 8'd0) begin errors++; $display("FAIL b2b_overrun got=%0d want=0", overrun_cnt); end
    rdy_mode = 0; gate_pct = 0; gate = 1'b0; m_tready = 1'b1; drive_fout();
  endtask

  task automatic test_overrun();
    apply_reset();
    fire(1'b1, 48'h10, 1'b1, 0); tick();
    fire(1'b1, 48'h20, 1'b1, 0); tick();
    fire(1'b1, 48'h30, 1'b0, 0); tick();
    checks++; if (overrun_cnt !== 8'd1) begin errors++; $display("FAIL ovr_cnt got=%0d want=1", overrun_cnt); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ovr_busy got=%b want=1", busy); end
    for (int i = 0; i < 100 && busy; i++) tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ovr_timeout busy=%b want=0", busy); end
    checks++;
    if (got.size() != exp.size()) begin errors++; $display("FAIL ovr_len got=%0d want=%0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp[i]) begin errors++; $display("FAIL ovr_word[%0d] got=%h want=%h", i, got[i], exp[i]); end
    end
    checks++;
    if (got.size() > WIN_LEN + 2 && got[WIN_LEN + 2] !== {1'b0, 32'hED01_0001}) begin
      errors++; $display("FAIL ovr_second_hdr got=%h want=0ed010001", got[WIN_LEN + 2]);
    end
  endtask

  task automatic test_wrap_sat();
    int n;
    apply_reset();
    m_tready = 1'b0;
    fire(1'b1, 48'h123, 1'b1, 0); tick();
    fire(1'b0, 48'h9, 1'b1, 0); tick();
    for (int i = 0; i < 65534; i++) begin fire(1'b1, 48'h1, 1'b0, 0); tick(); end
    checks++; if (overrun_cnt !== 8'd255) begin errors++; $display("FAIL sat_overrun got=%0d want=255", overrun_cnt); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wrap_busy got=%b want=1", busy); end
    m_tready = 1'b1; rdy_mode = 1;
    for (int i = 0; i < 200 && busy; i++) tick();
    fire(1'b1, 48'h1_0000_0000, 1'b1, 0); tick();
    for (int i = 0; i < 200 && busy; i++) tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wrap_timeout busy=%b want=0", busy); end
    checks++;
    if (got.size() != exp.size()) begin errors++; $display("FAIL wrap_len got=%0d want=%0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp[i]) begin errors++; $display("FAIL wrap_word[%0d] got=%h want=%h", i, got[i], exp[i]); end
    end
    n = got.size();
    checks++;
    if (n < WIN_LEN + 2 || got[n - WIN_LEN - 2] !== {1'b0, 32'hED01_0000}) begin
      errors++; $display("FAIL wrap_idx got=%h want=0ed010000", (n >= WIN_LEN + 2) ? got[n - WIN_LEN - 2] : '0);
    end
    checks++;
    if (n < WIN_LEN + 1 || got[n - WIN_LEN - 1] !== {1'b0, 32'hFFFF_FFFF}) begin
      errors++; $display("FAIL sat_energy got=%h want=0ffffffff", (n >= WIN_LEN + 1) ? got[n - WIN_LEN - 1] : '0);
    end
    rdy_mode = 0; m_tready = 1'b1;
  endtask

  task automatic test_reset_mid();
    m_tready = 1'b1;
    fire(1'b1, 48'hAB, 1'b1, 0); tick();
    fire(1'b1, 48'hCD, 1'b1, 0); tick();
    repeat (2) tick();
    checks++; if (m_tvalid !== 1'b1) begin errors++; $display("FAIL mid_pre_tvalid got=%b want=1", m_tvalid); end
    reset = 1'b1;
    #1;
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL mid_tvalid got=%b want=0", m_tvalid); end
    checks++; if (fout_pop !== 1'b0) begin errors++; $display("FAIL mid_pop got=%b want=0", fout_pop); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got=%b want=0", busy); end
    checks++; if (overrun_cnt !== 8'd0) begin errors++; $display("FAIL mid_overrun got=%0d want=0", overrun_cnt); end
    checks++; if (m_tlast !== 1'b0) begin errors++; $display("FAIL mid_tlast got=%b want=0", m_tlast); end
    clear_model();
    @(posedge clock); #1 reset = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_after busy=%b want=0", busy); end
  endtask

  initial begin
    drive_fout();
    test_reset();
    test_packet();
    test_discard();
    test_stall();
    test_back_to_back();
    test_overrun();
    test_wrap_sat();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
